// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART transmitter block.
// Holds the bus register offsets (address bits [3:2]), STATUS and CTRL bit
// positions, the BAUDDIV floor and the transmit FSM state encodings.
// Optional feature macro: UART_TX_PARITY_EN (adds the PARITY state).
package uart_tx_pkg;

    // Register offsets as decoded from bus_addr[3:2]
    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    // STATUS bit positions
    localparam int unsigned STAT_BUSY_BIT  = 0;
    localparam int unsigned STAT_FULL_BIT  = 1;
    localparam int unsigned STAT_EMPTY_BIT = 2;
    localparam int unsigned STAT_OVF_BIT   = 3;
    localparam int unsigned STAT_LEVEL_LSB = 8;

    // CTRL bit positions
    localparam int unsigned CTRL_EN_BIT     = 0;
    localparam int unsigned CTRL_PODD_BIT   = 1;
    localparam int unsigned CTRL_FLUSH_BIT  = 2;
    localparam int unsigned CTRL_CLROVF_BIT = 3;

    // Smallest usable bit divisor; lower programmed values are raised to this
    localparam logic [15:0] BAUDDIV_MIN = 16'd3;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } tx_state_t;

endpackage

// File: rtl/uart_tx_fifo_ip_fifo.sv
// sync_fifo: single-clock FIFO with first-word-fall-through read port.
// Ports: clk, resetn (sync, active-low), flush (synchronous clear),
//        push/push_data, pop/pop_data, full, empty, level (0..DEPTH).
// A push while full is accepted only when a pop happens in the same cycle.
// DEPTH must be a power of two (pointers wrap naturally).
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     flush,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign level    = count;
    assign pop_data = mem[rd_ptr];

    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (!resetn || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_tx_fifo_ip.sv
// uart_tx_fifo_ip: memory-mapped UART transmitter with a TX FIFO.
// Ports: clk, resetn (sync, active-low), bus_valid/bus_we/bus_addr/bus_wdata
//        (one-cycle access strobe, addr[3:2] decoded), bus_rdata (registered),
//        uart_tx (serial out, idle high), tx_idle (FIFO empty and FSM idle).
// Registers: 0x0 DATA (W), 0x4 STATUS (R), 0x8 BAUDDIV (RW), 0xC CTRL (RW).
// Optional feature macro: UART_TX_PARITY_EN (parity bit, CTRL bit1 parity_odd).
module uart_tx_fifo_ip
    import uart_tx_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 12_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned FIFO_DEPTH  = 16
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        bus_valid,
    input  logic        bus_we,
    input  logic [31:0] bus_addr,
    input  logic [31:0] bus_wdata,
    output logic [31:0] bus_rdata,
    output logic        uart_tx,
    output logic        tx_idle
);

    localparam int unsigned LW          = $clog2(FIFO_DEPTH) + 1;
    localparam logic [15:0] BAUDDIV_RST = 16'(CLK_FREQ_HZ / BAUD_RATE - 1);

    // Bus decode
    logic [1:0]  reg_sel;
    logic        wr_acc;
    logic        rd_acc;
    logic        data_push;
    logic        ctrl_wr;
    logic        flush;

    // Control / status registers
    logic [15:0] baud_div;
    logic        enable;
    logic        parity_odd;
    logic        overflow;
    logic [31:0] rd_mux;

    // FIFO
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_dout;
    logic [LW-1:0] fifo_level;
    logic [8:0]  level9;

    // Transmit FSM
    tx_state_t   state;
    tx_state_t   state_nx;
    logic [15:0] baud_cnt;
    logic [15:0] frame_div;
    logic [15:0] eff_div;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_reg;
    logic        parity_bit;
    logic        tx_q;
    logic        tx_nx;
    logic        bit_done;
    logic        start_ok;

    logic        unused_bits;

    assign reg_sel   = bus_addr[3:2];
    assign wr_acc    = bus_valid && bus_we;
    assign rd_acc    = bus_valid && !bus_we;
    assign data_push = wr_acc && (reg_sel == REG_DATA);
    assign ctrl_wr   = wr_acc && (reg_sel == REG_CTRL);
    assign flush     = ctrl_wr && bus_wdata[CTRL_FLUSH_BIT];

    assign level9      = 9'(fifo_level);
    assign unused_bits = ^{bus_addr[31:4], bus_addr[1:0], bus_wdata[31:16], level9[8]};

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .flush     (flush),
        .push      (data_push),
        .push_data (bus_wdata[7:0]),
        .pop       (fifo_pop),
        .pop_data  (fifo_dout),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (fifo_level)
    );

    // ---------------- Register file ----------------
    always_ff @(posedge clk) begin
        if (!resetn) begin
            baud_div <= BAUDDIV_RST;
            enable   <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (wr_acc && (reg_sel == REG_BAUDDIV)) baud_div <= bus_wdata[15:0];
            if (ctrl_wr) enable <= bus_wdata[CTRL_EN_BIT];
            // A full-FIFO push is only lost if no pop frees a slot this cycle
            if (data_push && fifo_full && !fifo_pop)
                overflow <= 1'b1;
            else if (ctrl_wr && bus_wdata[CTRL_CLROVF_BIT])
                overflow <= 1'b0;
        end
    end

`ifdef UART_TX_PARITY_EN
    always_ff @(posedge clk) begin
        if (!resetn)      parity_odd <= 1'b0;
        else if (ctrl_wr) parity_odd <= bus_wdata[CTRL_PODD_BIT];
    end
`else
    assign parity_odd = 1'b0;
`endif

    always_comb begin
        rd_mux = '0;
        case (reg_sel)
            REG_STATUS: begin
                rd_mux[STAT_BUSY_BIT]  = (state != S_IDLE);
                rd_mux[STAT_FULL_BIT]  = fifo_full;
                rd_mux[STAT_EMPTY_BIT] = fifo_empty;
                rd_mux[STAT_OVF_BIT]   = overflow;
                rd_mux[STAT_LEVEL_LSB +: 8] = level9[7:0];
            end
            REG_BAUDDIV: rd_mux[15:0] = baud_div;
            REG_CTRL: begin
                rd_mux[CTRL_EN_BIT]   = enable;
                rd_mux[CTRL_PODD_BIT] = parity_odd;
            end
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn)     bus_rdata <= '0;
        else if (rd_acc) bus_rdata <= rd_mux;
    end

    // ---------------- Transmit FSM ----------------
    assign bit_done = (baud_cnt == frame_div);
    assign eff_div  = (baud_div < BAUDDIV_MIN) ? BAUDDIV_MIN : baud_div;
    assign start_ok = enable && !fifo_empty;

    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        tx_nx    = 1'b1;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
                    state_nx = S_START;
                    fifo_pop = 1'b1;
                end
            end
            S_START: if (bit_done) state_nx = S_DATA;
            S_DATA: begin
                if (bit_done && (bit_cnt == 3'd7))
`ifdef UART_TX_PARITY_EN
                    state_nx = S_PARITY;
`else
                    state_nx = S_STOP;
`endif
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: if (bit_done) state_nx = S_STOP;
`endif
            S_STOP: begin
                if (bit_done) begin
                    if (start_ok) begin
                        state_nx = S_START;
                        fifo_pop = 1'b1;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            default: state_nx = S_IDLE;
        endcase

        // uart_tx is registered, so drive the level belonging to the next state;
        // within DATA the shifter advances on bit_done, hence bit [1] then.
        case (state_nx)
            S_START: tx_nx = 1'b0;
            S_DATA:  tx_nx = (state == S_DATA && bit_done) ? shift_reg[1] : shift_reg[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_nx = parity_bit;
`endif
            default: tx_nx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            frame_div  <= BAUDDIV_RST;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            state <= state_nx;
            tx_q  <= tx_nx;

            if (fifo_pop) begin
                shift_reg  <= fifo_dout;
                frame_div  <= eff_div;
                parity_bit <= (^fifo_dout) ^ parity_odd;
            end else if (state == S_DATA && bit_done) begin
                shift_reg <= {1'b0, shift_reg[7:1]};
            end

            if (bit_done || state == S_IDLE) baud_cnt <= '0;
            else                             baud_cnt <= baud_cnt + 16'd1;

            if (state == S_START)                   bit_cnt <= '0;
            else if (state == S_DATA && bit_done)   bit_cnt <= bit_cnt + 3'd1;
        end
    end

    assign uart_tx = tx_q;
    assign tx_idle = (state == S_IDLE) && fifo_empty;

endmodule

// File: tb/tb_uart_tx_fifo_ip.sv
// tb_uart_tx_fifo_ip: self-checking bench for uart_tx_fifo_ip.
// Bytes written to DATA are pushed to a scoreboard queue and popped when the
// serial receiver below decodes a frame on uart_tx.
// Honours UART_TX_PARITY_EN when defined for the build.
module tb_uart_tx_fifo_ip;

`ifdef UART_TX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        bus_valid;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;
    logic        uart_tx;
    logic        tx_idle;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    // receiver results used by forked threads
    logic [7:0] rx_d;
    logic       rx_p;
    logic       rx_stop;
    int         rx_wait;
    bit         rx_to;

    always #5 clk = ~clk;

    uart_tx_fifo_ip #(
        .CLK_FREQ_HZ (12_000_000),
        .BAUD_RATE   (9600),
        .FIFO_DEPTH  (16)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .bus_valid (bus_valid),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .uart_tx   (uart_tx),
        .tx_idle   (tx_idle)
    );

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic bus_write(input logic [31:0] addr, input logic [31:0] data);
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b1; bus_addr = addr; bus_wdata = data;
        @(negedge clk);
        bus_valid = 1'b0; bus_we = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] addr, output logic [31:0] data);
        @(negedge clk);
        bus_valid = 1'b1; bus_we = 1'b0; bus_addr = addr;
        @(negedge clk);
        bus_valid = 1'b0;
        data = bus_rdata;
    endtask

    task automatic push_byte(input logic [7:0] b, input bit accepted);
        bus_write(32'h0, {24'h0, b});
        if (accepted) exp_q.push_back(b);
    endtask

    // Waits for a start bit then samples each bit at its centre.
    task automatic rx_capture(input int bit_clks, input bit with_par,
                              output logic [7:0] d, output logic p,
                              output logic stop, output int wait_cycles,
                              output bit to);
        d = '0; p = 1'b0; stop = 1'b0; wait_cycles = 0; to = 1'b0;
        do begin
            @(negedge clk);
            wait_cycles++;
        end while (uart_tx !== 1'b0 && wait_cycles < 5000);
        if (uart_tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        repeat (bit_clks / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            repeat (bit_clks) @(negedge clk);
            d[i] = uart_tx;
        end
        if (with_par) begin
            repeat (bit_clks) @(negedge clk);
            p = uart_tx;
        end
        repeat (bit_clks) @(negedge clk);
        stop = uart_tx;
    endtask

    task automatic test_reset;
        logic [31:0] r;
        resetn = 1'b0; bus_valid = 1'b0; bus_we = 1'b0; bus_addr = '0; bus_wdata = '0;
        repeat (3) @(negedge clk);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL reset_uart_tx got %b want 1", uart_tx); end
        n_checks++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL reset_tx_idle got %b want 1", tx_idle); end
        n_checks++; if (bus_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata got %h want 0", bus_rdata); end
        resetn = 1'b1;
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL reset_status got %h want 00000004", r); end
        bus_read(32'h8, r);
        n_checks++; if (r !== 32'd1249) begin n_fail++; $display("FAIL reset_bauddiv got %0d want 1249", r); end
        bus_read(32'hC, r);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL reset_ctrl got %h want 1", r); end
        bus_read(32'h0, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL data_read got %h want 0", r); end
    endtask

    task automatic test_frame_waveform;
        logic [7:0] b;
        logic       want;
        int         idx;
        bus_write(32'h8, 32'd9);
        push_byte(8'h55, 1'b1);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL wave_pre_start got %b want 1", uart_tx); end
        b = exp_q.pop_front();
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            idx = k / 10;
            if (idx == 0)      want = 1'b0;
            else if (idx <= 8) want = b[idx-1];
            else               want = 1'b1;
            n_checks++;
            if (uart_tx !== want) begin
                n_fail++; $display("FAIL wave_clk%0d got %b want %b", k, uart_tx, want);
            end
        end
        n_checks++; if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL wave_idle_in_stop got %b want 0", tx_idle); end
        @(negedge clk);
        n_checks++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL wave_idle_after got %b want 1", tx_idle); end
    endtask

    task automatic test_overflow;
        logic [31:0] r;
        bus_write(32'h8, 32'd3);
        bus_write(32'hC, 32'h0);
        for (int i = 0; i < 17; i++) push_byte(8'(i * 37 + 11), i < 16);
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h0000_100A) begin n_fail++; $display("FAIL ovf_status got %h want 0000100a", r); end
        bus_write(32'hC, 32'h8);
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h0000_1002) begin n_fail++; $display("FAIL ovf_clear got %h want 00001002", r); end
        bus_read(32'hC, r);
        n_checks++; if (r !== 32'h0) begin n_fail++; $display("FAIL ovf_ctrl got %h want 0", r); end
    endtask

    task automatic test_back_to_back;
        logic [7:0]  d, want;
        logic        p, stop;
        int          w, c;
        bit          to;
        logic [31:0] r;
        bus_write(32'hC, 32'h1);
        for (int i = 0; i < 16; i++) begin
            rx_capture(4, PAR, d, p, stop, w, to);
            n_checks++;
            if (to !== 1'b0) begin n_fail++; $display("FAIL b2b_timeout frame %0d", i); break; end
            want = exp_q.pop_front();
            n_checks++; if (d !== want) begin n_fail++; $display("FAIL b2b_data%0d got %h want %h", i, d, want); end
            n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL b2b_stop%0d got %b want 1", i, stop); end
            if (i > 0) begin
                n_checks++; if (w !== 2) begin n_fail++; $display("FAIL b2b_gap%0d got %0d want 2", i, w); end
            end
        end
        n_checks++; if (tx_idle !== 1'b0) begin n_fail++; $display("FAIL b2b_idle_in_stop got %b want 0", tx_idle); end
        c = 0;
        do begin @(negedge clk); c++; end while (tx_idle !== 1'b1 && c < 100);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL b2b_idle_rise got %0d clocks want 2", c); end
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL b2b_status got %h want 00000004", r); end
    endtask

    task automatic test_enable_clear_mid_frame;
        logic [31:0] r;
        logic [7:0]  want;
        bus_write(32'h8, 32'd3);
        bus_write(32'hC, 32'h1);
        fork
            rx_capture(4, PAR, rx_d, rx_p, rx_stop, rx_wait, rx_to);
            begin
                push_byte(8'hC3, 1'b1);
                push_byte(8'h3C, 1'b1);
                bus_write(32'h8, 32'd7);
                bus_write(32'hC, 32'h0);
            end
        join
        n_checks++; if (rx_to !== 1'b0) begin n_fail++; $display("FAIL en_timeout got %b want 0", rx_to); end
        want = exp_q.pop_front();
        n_checks++; if (rx_d !== want) begin n_fail++; $display("FAIL en_data got %h want %h", rx_d, want); end
        repeat (4) @(negedge clk);
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h0000_0100) begin n_fail++; $display("FAIL en_status got %h want 00000100", r); end
        bus_read(32'h8, r);
        n_checks++; if (r !== 32'd7) begin n_fail++; $display("FAIL en_bauddiv got %0d want 7", r); end
        bus_write(32'hC, 32'h4);
        void'(exp_q.pop_back());
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL flush_status got %h want 00000004", r); end
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL flush_line got %b want 1", uart_tx); end
    endtask

    task automatic test_parity;
        logic [31:0] r;
        logic [7:0]  d, want;
        logic        p, stop;
        int          w, c;
        bit          to;
        bus_write(32'h8, 32'd3);
`ifdef UART_TX_PARITY_EN
        bus_write(32'hC, 32'h1);
        push_byte(8'h07, 1'b1);
        rx_capture(4, 1'b1, d, p, stop, w, to);
        want = exp_q.pop_front();
        n_checks++; if (d !== want || to) begin n_fail++; $display("FAIL par_even_data got %h want %h", d, want); end
        n_checks++; if (p !== 1'b1) begin n_fail++; $display("FAIL par_even_bit got %b want 1", p); end
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL par_even_stop got %b want 1", stop); end
        bus_write(32'hC, 32'h3);
        bus_read(32'hC, r);
        n_checks++; if (r !== 32'h3) begin n_fail++; $display("FAIL par_ctrl got %h want 3", r); end
        push_byte(8'h07, 1'b1);
        rx_capture(4, 1'b1, d, p, stop, w, to);
        want = exp_q.pop_front();
        n_checks++; if (d !== want || to) begin n_fail++; $display("FAIL par_odd_data got %h want %h", d, want); end
        n_checks++; if (p !== 1'b0) begin n_fail++; $display("FAIL par_odd_bit got %b want 0", p); end
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL par_odd_stop got %b want 1", stop); end
`else
        bus_write(32'hC, 32'h3);
        bus_read(32'hC, r);
        n_checks++; if (r !== 32'h1) begin n_fail++; $display("FAIL nopar_ctrl got %h want 1", r); end
        push_byte(8'h07, 1'b1);
        rx_capture(4, 1'b0, d, p, stop, w, to);
        want = exp_q.pop_front();
        n_checks++; if (d !== want || to) begin n_fail++; $display("FAIL nopar_data got %h want %h", d, want); end
        n_checks++; if (stop !== 1'b1) begin n_fail++; $display("FAIL nopar_stop got %b want 1", stop); end
`endif
        c = 0;
        do begin @(negedge clk); c++; end while (tx_idle !== 1'b1 && c < 100);
        n_checks++; if (c !== 2) begin n_fail++; $display("FAIL par_frame_end got %0d clocks want 2", c); end
        bus_write(32'hC, 32'h1);
    endtask

    task automatic test_reset_mid_frame;
        logic [31:0] r;
        bus_write(32'h8, 32'd9);
        bus_write(32'hC, 32'h1);
        push_byte(8'h00, 1'b1);
        repeat (30) @(negedge clk);
        n_checks++; if (uart_tx !== 1'b0) begin n_fail++; $display("FAIL rst_mid_pre got %b want 0", uart_tx); end
        resetn = 1'b0;
        @(negedge clk);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_line got %b want 1", uart_tx); end
        n_checks++; if (tx_idle !== 1'b1) begin n_fail++; $display("FAIL rst_mid_idle got %b want 1", tx_idle); end
        resetn = 1'b1;
        exp_q.delete();
        repeat (5) @(negedge clk);
        n_checks++; if (uart_tx !== 1'b1) begin n_fail++; $display("FAIL rst_mid_after got %b want 1", uart_tx); end
        bus_read(32'h4, r);
        n_checks++; if (r !== 32'h4) begin n_fail++; $display("FAIL rst_mid_status got %h want 00000004", r); end
        bus_read(32'h8, r);
        n_checks++; if (r !== 32'd1249) begin n_fail++; $display("FAIL rst_mid_bauddiv got %0d want 1249", r); end
    endtask

    initial begin
        test_reset();
        test_frame_waveform();
        test_overflow();
        test_back_to_back();
        test_enable_clear_mid_frame();
        test_parity();
        test_reset_mid_frame();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_fail++; $display("FAIL scoreboard_left got %0d entries want 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
